chacha20_poly1305_seq: RTL and testbench
========================================

Name: chacha20_poly1305_seq

Overview:
Bus-master sequencer that runs one complete AEAD job on the chacha20_poly1305_bus register interface without software involvement. It accepts a job (key, nonce, 2 data words) over a valid/ready handshake and writes the key, nonce and data registers. It then issues init/next/done control writes, polling status between them, reads back the 128-bit tag and returns it on a response handshake. It sits between a job source (DMA/CPU mailbox) and the crypto core's register port.

Parameters:
POLL_MAX, 16, max status reads per poll phase before abort with error
TAG_BASE, 8'h40, first of 4 consecutive tag read addresses

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  job offered
job_ready  out  1  high only in IDLE
job_key  in  256  key; [255:224] goes to 0x10 … [31:0] goes to 0x17
job_nonce  in  96  nonce; [95:64] goes to 0x20 … [31:0] goes to 0x22
job_data  in  64  data; [63:32] goes to 0x30, [31:0] goes to 0x31
resp_valid  out  1  result available, held until resp_ready
resp_ready  in  1  result consumed
resp_tag  out  128  word from TAG_BASE in [127:96] … TAG_BASE+3 in [31:0]
resp_err  out  1  poll timeout occurred
busy  out  1  not IDLE
bus_cs  out  1  register access strobe
bus_we  out  1  write enable (valid with bus_cs)
bus_addr  out  8  register address
bus_wdata  out  32  write data
bus_rdata  in  32  read data, combinational from bus_addr while bus_cs=1 & bus_we=0

Behaviour:
- Reset values: job_ready=1, resp_valid=0, resp_tag=0, resp_err=0, busy=0, bus_cs=0, bus_we=0, bus_addr=0, bus_wdata=0. A rst asserted mid-job returns the block to IDLE at that edge. bus_cs is 0 from the next cycle. The partial job is dropped with no response.
- Job is accepted on the edge where job_valid & job_ready. job_key/nonce/data are latched into internal registers at that edge. Inputs are ignored afterwards.
- Access slot: every access is 2 cycles.
  - Cycle A: bus_cs=1 with bus_we/addr/wdata valid.
  - Cycle B: bus_cs=0 idle gap.
  - For a read, bus_rdata is sampled at the edge ending cycle A.
  - No back-to-back cs cycles.
- Control register 0x08: bit0 init, bit1 next, bit2 done (written as 1, 2, 4). Status register 0x09: bit0 ready, bit1 tag_valid.
- FSM sequence:
  - IDLE
  - WR_KEY: 8 writes, 0x10..0x17
  - WR_NONCE: 3 writes, 0x20..0x22
  - WR_DATA: 2 writes, 0x30..0x31
  - WR_INIT: write 0x08=1
  - POLL_INIT: read 0x09 until bit0=1
  - WR_NEXT: write 0x08=2
  - POLL_NEXT: read 0x09 until bit0=1
  - WR_DONE: write 0x08=4
  - POLL_DONE: read 0x09 until bit1=1
  - RD_TAG: 4 reads, TAG_BASE..TAG_BASE+3
  - RESP
  - back to IDLE
- Poll counter resets on entry to each poll phase. If POLL_MAX consecutive reads fail, the block skips to RESP with resp_err=1 and resp_tag=0.
- Timing: cycle 0 is the acceptance edge. Access k (k≥1) has cs high in cycle 2k-1. With N accesses, resp_valid rises in cycle 2N+1. In the no-wait case N=23, so resp_valid rises in cycle 47.
- RESP: resp_valid stays 1 and resp_tag/resp_err stay stable until resp_ready is sampled high. The FSM then goes to IDLE and job_ready=1 in the next cycle. resp_err clears on the next job acceptance.
- job_valid while busy: job_ready=0, so nothing is accepted and no state changes.
- Address counters wrap only within a phase. Word index width is 3 bits. Phase transitions occur exactly after the final word.

Decomposition:
- Package chacha20_poly1305_pkg:
  - register address constants: ADDR_CTRL 8'h08, ADDR_STATUS 8'h09, ADDR_KEY 8'h10, ADDR_NONCE 8'h20, ADDR_DATA 8'h30
  - CTRL_INIT/NEXT/DONE values
  - STATUS_READY/TAG_VALID bit indices
  - FSM state enum
- One sub-module, chacha20_poly1305_bus_req: performs a single read/write access slot. It has a start/done handshake, drives cs/we/addr/wdata, and captures rdata. The FSM remains in chacha20_poly1305_seq.

Test Plan:
- Basic job: key=00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface, nonce=01010101_02020202_03030303, data=aaaaaaaa_bbbbbbbb. Core model reports ready/tag_valid immediately.
  - Expected write order: 0x10=00112233 … 0x17=feedface, 0x20..0x22, 0x30=aaaaaaaa, 0x31=bbbbbbbb, 0x08=1, 0x08=2, 0x08=4.
  - resp_valid must rise in cycle 47 with resp_tag equal to the model's 4 tag words.
- Poll wait: model holds ready=0 for 5 reads after init. Expect exactly 6 reads of 0x09 before the next write, and resp_valid 10 cycles later than in the basic job.
- Timeout: model never sets tag_valid. Expect exactly POLL_MAX=16 reads of 0x09 in POLL_DONE, then resp_valid=1, resp_err=1, resp_tag=0, and no reads of TAG_BASE.
- Backpressure: hold resp_ready=0 for 10 cycles. resp_valid/resp_tag must stay stable, job_ready=0, and a job_valid offered meanwhile is not accepted until 1 cycle after resp_ready.
- Reset mid-op: assert rst during WR_NONCE. At the next edge bus_cs=0, busy=0, job_ready=1, and resp_valid never asserts. A subsequent job completes normally.
- Bus protocol checker, on all tests: bus_cs is never high in 2 consecutive cycles, and bus_we/addr/wdata are stable whenever cs=1.

Source files
------------

// File: rtl/chacha20_poly1305_pkg.sv
// ---------------------------------------------------------------------------
// chacha20_poly1305_pkg
// Shared constants for the AEAD job sequencer:
//   - register map of the crypto core's register port
//   - control register command values and status register bit positions
//   - sequencer FSM state encodings and access-slot phase encodings
//   - is_access(): true for states that perform a bus access
// ---------------------------------------------------------------------------
package chacha20_poly1305_pkg;

  // Register map
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_NONCE  = 8'h20;
  localparam logic [7:0] ADDR_DATA   = 8'h30;

  // Control register commands
  localparam logic [31:0] CTRL_INIT = 32'd1;
  localparam logic [31:0] CTRL_NEXT = 32'd2;
  localparam logic [31:0] CTRL_DONE = 32'd4;

  // Status register bit indices
  localparam int STATUS_READY     = 0;
  localparam int STATUS_TAG_VALID = 1;

  // Sequencer FSM states
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_WR_KEY    = 4'd1;
  localparam state_t S_WR_NONCE  = 4'd2;
  localparam state_t S_WR_DATA   = 4'd3;
  localparam state_t S_WR_INIT   = 4'd4;
  localparam state_t S_POLL_INIT = 4'd5;
  localparam state_t S_WR_NEXT   = 4'd6;
  localparam state_t S_POLL_NEXT = 4'd7;
  localparam state_t S_WR_DONE   = 4'd8;
  localparam state_t S_POLL_DONE = 4'd9;
  localparam state_t S_RD_TAG    = 4'd10;
  localparam state_t S_RESP      = 4'd11;

  // Access slot phases: strobe cycle followed by a mandatory idle gap
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_CS   = 2'd1;
  localparam logic [1:0] PH_GAP  = 2'd2;

  // Every state except IDLE and RESP issues register accesses
  function automatic logic is_access(input state_t s);
    return (s != S_IDLE) && (s != S_RESP);
  endfunction

endpackage

// File: rtl/chacha20_poly1305_bus_req.sv
// ---------------------------------------------------------------------------
// chacha20_poly1305_bus_req
// Performs one register access slot: one cycle with bus_cs high, then one
// idle gap cycle. A new start may be accepted during the gap cycle so that
// consecutive slots are packed with exactly one idle cycle between strobes.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  launch an access using we/addr/wdata
//   we, addr, wdata        access descriptor, sampled on the launching edge
//   done                   high during the gap cycle of a finished access
//   idle                   no access in flight
//   rdata                  read data captured at the end of the strobe cycle
//   bus_cs/we/addr/wdata   register port request (registered)
//   bus_rdata              register port read data
// ---------------------------------------------------------------------------
module chacha20_poly1305_bus_req
  import chacha20_poly1305_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        idle,
  output logic [31:0] rdata,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  logic [1:0] phase;

  // Request fields stay registered and unchanged for the whole strobe cycle;
  // they are left as-is after the strobe so the port does not toggle idly.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PH_IDLE;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 8'h00;
      bus_wdata <= 32'h0;
      rdata     <= 32'h0;
    end else begin
      case (phase)
        PH_CS: begin
          bus_cs <= 1'b0;
          phase  <= PH_GAP;
          if (!bus_we) rdata <= bus_rdata;
        end
        default: begin
          if (start) begin
            phase     <= PH_CS;
            bus_cs    <= 1'b1;
            bus_we    <= we;
            bus_addr  <= addr;
            bus_wdata <= wdata;
          end else begin
            phase <= PH_IDLE;
          end
        end
      endcase
    end
  end

  assign done = (phase == PH_GAP);
  assign idle = (phase == PH_IDLE);

endmodule

// File: rtl/chacha20_poly1305_seq.sv
// ---------------------------------------------------------------------------
// chacha20_poly1305_seq
// Bus-master sequencer that runs one AEAD job on the crypto core's register
// port: writes key/nonce/data, issues init/next/done with status polling in
// between, reads back the 128-bit tag and returns it on a response handshake.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   job_valid/job_ready              job handshake (ready only when idle)
//   job_key/job_nonce/job_data       job payload, latched at acceptance
//   resp_valid/resp_ready            response handshake
//   resp_tag, resp_err               tag words and poll-timeout flag
//   busy                             sequencer not idle
//   bus_cs/we/addr/wdata, bus_rdata  register port master
// ---------------------------------------------------------------------------
module chacha20_poly1305_seq
  import chacha20_poly1305_pkg::*;
#(
  parameter int         POLL_MAX = 16,
  parameter logic [7:0] TAG_BASE = 8'h40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_key,
  input  logic [95:0]  job_nonce,
  input  logic [63:0]  job_data,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_tag,
  output logic         resp_err,
  output logic         busy,
  output logic         bus_cs,
  output logic         bus_we,
  output logic [7:0]   bus_addr,
  output logic [31:0]  bus_wdata,
  input  logic [31:0]  bus_rdata
);

  localparam int PW = $clog2(POLL_MAX + 1);

  state_t           state, next_state;
  logic [2:0]       idx, next_idx;
  logic [PW-1:0]    poll_cnt;
  logic             poll_last;
  logic             timeout;
  logic [7:0][31:0] key_q;
  logic [2:0][31:0] nonce_q;
  logic [1:0][31:0] data_q;

  logic        req_start, req_we, req_done, req_idle;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata, req_rdata;

  assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));

  // Next-state logic. Access states only advance when the current slot
  // finishes (req_done); the word index restarts at 0 on every phase change.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          next_state = S_WR_KEY;
          next_idx   = 3'd0;
        end
      end
      S_RESP: begin
        if (resp_ready) next_state = S_IDLE;
      end
      default: begin
        if (req_done) begin
          next_idx = 3'd0;
          case (state)
            S_WR_KEY:    if (idx == 3'd7) next_state = S_WR_NONCE;
                         else next_idx = idx + 3'd1;
            S_WR_NONCE:  if (idx == 3'd2) next_state = S_WR_DATA;
                         else next_idx = idx + 3'd1;
            S_WR_DATA:   if (idx == 3'd1) next_state = S_WR_INIT;
                         else next_idx = idx + 3'd1;
            S_WR_INIT:   next_state = S_POLL_INIT;
            S_POLL_INIT: begin
              if (req_rdata[STATUS_READY]) next_state = S_WR_NEXT;
              else if (poll_last) begin
                next_state = S_RESP;
                timeout    = 1'b1;
              end
            end
            S_WR_NEXT:   next_state = S_POLL_NEXT;
            S_POLL_NEXT: begin
              if (req_rdata[STATUS_READY]) next_state = S_WR_DONE;
              else if (poll_last) begin
                next_state = S_RESP;
                timeout    = 1'b1;
              end
            end
            S_WR_DONE:   next_state = S_POLL_DONE;
            S_POLL_DONE: begin
              if (req_rdata[STATUS_TAG_VALID]) next_state = S_RD_TAG;
              else if (poll_last) begin
                next_state = S_RESP;
                timeout    = 1'b1;
              end
            end
            S_RD_TAG:    if (idx == 3'd3) next_state = S_RESP;
                         else next_idx = idx + 3'd1;
            default:     next_state = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // The access descriptor is derived from the next state/index so that the
  // following slot can be launched during the gap cycle of the current one.
  always_comb begin
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    case (next_state)
      S_WR_KEY: begin
        req_we    = 1'b1;
        req_addr  = ADDR_KEY + {5'b0, next_idx};
        req_wdata = key_q[3'd7 - next_idx];
      end
      S_WR_NONCE: begin
        req_we   = 1'b1;
        req_addr = ADDR_NONCE + {5'b0, next_idx};
        case (next_idx[1:0])
          2'd0:    req_wdata = nonce_q[2];
          2'd1:    req_wdata = nonce_q[1];
          default: req_wdata = nonce_q[0];
        endcase
      end
      S_WR_DATA: begin
        req_we    = 1'b1;
        req_addr  = ADDR_DATA + {5'b0, next_idx};
        req_wdata = data_q[~next_idx[0]];
      end
      S_WR_INIT: begin
        req_we    = 1'b1;
        req_addr  = ADDR_CTRL;
        req_wdata = CTRL_INIT;
      end
      S_WR_NEXT: begin
        req_we    = 1'b1;
        req_addr  = ADDR_CTRL;
        req_wdata = CTRL_NEXT;
      end
      S_WR_DONE: begin
        req_we    = 1'b1;
        req_addr  = ADDR_CTRL;
        req_wdata = CTRL_DONE;
      end
      S_POLL_INIT, S_POLL_NEXT, S_POLL_DONE: req_addr = ADDR_STATUS;
      S_RD_TAG: req_addr = TAG_BASE + {5'b0, next_idx};
      default: ;
    endcase
  end

  // First slot of a job is launched from the cycle after acceptance (slot
  // engine idle); every later slot chains off the previous slot's gap cycle.
  assign req_start = is_access(next_state) &&
                     (req_done || (req_idle && is_access(state)));

  // State, counters, job payload and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= 3'd0;
      poll_cnt <= '0;
      key_q    <= '0;
      nonce_q  <= '0;
      data_q   <= '0;
      resp_tag <= 128'h0;
      resp_err <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      if (next_state != state)
        poll_cnt <= '0;
      else if (req_done &&
               (state == S_POLL_INIT || state == S_POLL_NEXT || state == S_POLL_DONE))
        poll_cnt <= poll_cnt + 1'b1;
      if (state == S_IDLE && job_valid) begin
        key_q    <= job_key;
        nonce_q  <= job_nonce;
        data_q   <= job_data;
        resp_tag <= 128'h0;
        resp_err <= 1'b0;
      end
      if (timeout) resp_err <= 1'b1;
      // Tag words shift in from the bottom so the first word ends on top
      if (state == S_RD_TAG && req_done)
        resp_tag <= {resp_tag[95:0], req_rdata};
    end
  end

  assign job_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);

  chacha20_poly1305_bus_req u_bus_req (
    .clk       (clk),
    .rst       (rst),
    .start     (req_start),
    .we        (req_we),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .done      (req_done),
    .idle      (req_idle),
    .rdata     (req_rdata),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

endmodule

// File: tb/tb_chacha20_poly1305_seq.sv
// ---------------------------------------------------------------------------
// tb_chacha20_poly1305_seq
// Directed bench for the AEAD job sequencer. A small register-port model of
// the crypto core answers status and tag reads and logs every write.
// ---------------------------------------------------------------------------
module tb_chacha20_poly1305_seq;

  logic         clk;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_key;
  logic [95:0]  job_nonce;
  logic [63:0]  job_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_tag;
  logic         resp_err;
  logic         busy;
  logic         bus_cs;
  logic         bus_we;
  logic [7:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic [31:0]  bus_rdata;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [255:0] KEY1   = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface;
  localparam logic [95:0]  NONCE1 = 96'h01010101_02020202_03030303;
  localparam logic [63:0]  DATA1  = 64'haaaaaaaa_bbbbbbbb;
  localparam logic [255:0] KEY2   = 256'hf0f0f0f0_e1e1e1e1_d2d2d2d2_c3c3c3c3_b4b4b4b4_a5a5a5a5_96969696_87878787;
  localparam logic [127:0] TAG    = 128'hc0ffee00_12345678_9abcdef0_0badf00d;

  chacha20_poly1305_seq #(.POLL_MAX(16), .TAG_BASE(8'h40)) dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_key    (job_key),
    .job_nonce  (job_nonce),
    .job_data   (job_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err),
    .busy       (busy),
    .bus_cs     (bus_cs),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Core model state
  int          wait_reads = 0;
  bit          never_tag  = 1'b0;
  logic [31:0] last_ctrl  = 32'h0;
  int          stat_since_wr = 0;
  int          reads_before_next = 0;
  int          tag_reads = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  // Protocol checker state
  int          viol = 0;
  logic        prev_cs = 1'b0;
  logic        s_we;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;

  // Status: ready is held low for wait_reads reads after an init command
  always_comb begin
    bus_rdata = 32'hdeadbeef;
    if (bus_cs && !bus_we) begin
      if (bus_addr == 8'h09)
        bus_rdata = {30'b0, ~never_tag, !(last_ctrl == 32'd1 && stat_since_wr < wait_reads)};
      else if (bus_addr == 8'h40) bus_rdata = TAG[127:96];
      else if (bus_addr == 8'h41) bus_rdata = TAG[95:64];
      else if (bus_addr == 8'h42) bus_rdata = TAG[63:32];
      else if (bus_addr == 8'h43) bus_rdata = TAG[31:0];
    end
  end

  always @(negedge clk) begin
    s_we    <= bus_we;
    s_addr  <= bus_addr;
    s_wdata <= bus_wdata;
  end

  always @(posedge clk) begin
    prev_cs <= bus_cs;
    viol <= viol + ((bus_cs && prev_cs) ? 1 : 0) +
            ((bus_cs && (bus_we !== s_we || bus_addr !== s_addr || bus_wdata !== s_wdata)) ? 1 : 0);
    if (bus_cs && bus_we) begin
      wr_addr.push_back(bus_addr);
      wr_data.push_back(bus_wdata);
      stat_since_wr <= 0;
      if (bus_addr == 8'h08) begin
        last_ctrl <= bus_wdata;
        if (bus_wdata == 32'd2) reads_before_next <= stat_since_wr;
      end
    end else if (bus_cs && !bus_we) begin
      if (bus_addr == 8'h09) stat_since_wr <= stat_since_wr + 1;
      if (bus_addr >= 8'h40 && bus_addr <= 8'h43) tag_reads <= tag_reads + 1;
    end
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Offers a job and returns at the negedge following the acceptance edge
  task automatic apply_stimulus(input logic [255:0] k, input logic [95:0] n,
                                input logic [63:0] d, output bit ok);
    int b = 0;
    @(negedge clk);
    job_key   = k;
    job_nonce = n;
    job_data  = d;
    job_valid = 1'b1;
    while (!job_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    ok = job_ready;
    if (ok) @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  // Counts cycles after acceptance until resp_valid; -1 if it never rises
  task automatic wait_resp(output int rise);
    int n = 0;
    while (!resp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    rise = resp_valid ? n : -1;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  logic [7:0]  exp_addr[16];
  logic [31:0] exp_data[16];
  logic [255:0] key_tmp;
  logic [95:0]  nonce_tmp;

  initial begin
    bit ok;
    int rise;
    int base_w;
    int base_t;
    int bad;

    key_tmp   = KEY1;
    nonce_tmp = NONCE1;
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 8'h10 + 8'(i);
      exp_data[i] = key_tmp[255 - 32*i -: 32];
    end
    for (int i = 0; i < 3; i++) begin
      exp_addr[8+i] = 8'h20 + 8'(i);
      exp_data[8+i] = nonce_tmp[95 - 32*i -: 32];
    end
    exp_addr[11] = 8'h30; exp_data[11] = 32'haaaaaaaa;
    exp_addr[12] = 8'h31; exp_data[12] = 32'hbbbbbbbb;
    exp_addr[13] = 8'h08; exp_data[13] = 32'd1;
    exp_addr[14] = 8'h08; exp_data[14] = 32'd2;
    exp_addr[15] = 8'h08; exp_data[15] = 32'd4;

    rst = 1'b1;
    job_valid = 1'b0;
    resp_ready = 1'b0;
    job_key = '0;
    job_nonce = '0;
    job_data = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check_output("rst_job_ready", job_ready, 1);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_tag", resp_tag, 0);
    check_output("rst_resp_err", resp_err, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_bus_cs", bus_cs, 0);
    check_output("rst_bus_we", bus_we, 0);
    check_output("rst_bus_addr", bus_addr, 0);
    check_output("rst_bus_wdata", bus_wdata, 0);
    rst = 1'b0;

    // Basic job, core ready immediately
    $display("[TB] basic job");
    base_w = wr_addr.size();
    base_t = tag_reads;
    apply_stimulus(KEY1, NONCE1, DATA1, ok);
    check_output("basic_accept", ok, 1);
    wait_resp(rise);
    check_output("basic_rise", rise, 47);
    check_output("basic_tag", resp_tag, TAG);
    check_output("basic_err", resp_err, 0);
    check_output("basic_wr_cnt", wr_addr.size() - base_w, 16);
    for (int i = 0; i < 16; i++) begin
      if (base_w + i < wr_addr.size())
        check_output($sformatf("basic_wr%0d", i),
                     {wr_addr[base_w+i], wr_data[base_w+i]}, {exp_addr[i], exp_data[i]});
      else
        check_output($sformatf("basic_wr%0d", i), '1, {exp_addr[i], exp_data[i]});
    end
    check_output("basic_init_polls", reads_before_next, 1);
    check_output("basic_tag_reads", tag_reads - base_t, 4);
    release_resp();
    check_output("basic_idle", job_ready, 1);

    // Poll wait: ready low for 5 reads after init
    $display("[TB] poll wait");
    wait_reads = 5;
    apply_stimulus(KEY1, NONCE1, 64'h01234567_89abcdef, ok);
    check_output("wait_accept", ok, 1);
    wait_resp(rise);
    check_output("wait_rise", rise, 57);
    check_output("wait_init_polls", reads_before_next, 6);
    check_output("wait_tag", resp_tag, TAG);
    check_output("wait_err", resp_err, 0);
    release_resp();
    wait_reads = 0;

    // Timeout: tag_valid never set
    $display("[TB] poll timeout");
    never_tag = 1'b1;
    base_t = tag_reads;
    apply_stimulus(KEY1, NONCE1, DATA1, ok);
    check_output("tmo_accept", ok, 1);
    wait_resp(rise);
    check_output("tmo_rise", rise, 69);
    check_output("tmo_err", resp_err, 1);
    check_output("tmo_tag", resp_tag, 0);
    check_output("tmo_done_polls", stat_since_wr, 16);
    check_output("tmo_tag_reads", tag_reads - base_t, 0);
    release_resp();
    never_tag = 1'b0;

    // Backpressure, with a second job offered while the response is held
    $display("[TB] backpressure");
    apply_stimulus(KEY1, NONCE1, DATA1, ok);
    check_output("bp_accept", ok, 1);
    check_output("bp_err_cleared", resp_err, 0);
    wait_resp(rise);
    check_output("bp_rise", rise, 47);
    job_key   = KEY2;
    job_nonce = NONCE1;
    job_data  = DATA1;
    job_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b1 || resp_tag !== TAG || job_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    check_output("bp_hold", bad, 0);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("bp_resp_dropped", resp_valid, 0);
    check_output("bp_not_yet_accepted", job_ready, 1);
    base_w = wr_addr.size();
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    check_output("bp_accepted", busy, 1);
    wait_resp(rise);
    check_output("bp2_rise", rise, 47);
    check_output("bp2_tag", resp_tag, TAG);
    if (base_w < wr_addr.size())
      check_output("bp2_first_wr", {wr_addr[base_w], wr_data[base_w]}, {8'h10, 32'hf0f0f0f0});
    else
      check_output("bp2_first_wr", '1, {8'h10, 32'hf0f0f0f0});
    release_resp();

    // Reset during the nonce phase
    $display("[TB] reset mid-op");
    apply_stimulus(KEY1, NONCE1, DATA1, ok);
    check_output("rmo_accept", ok, 1);
    bad = 0;
    while (!(bus_cs && bus_addr == 8'h20) && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    check_output("rmo_reached_nonce", {bus_cs, bus_addr}, {1'b1, 8'h20});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rmo_cs", bus_cs, 0);
    check_output("rmo_busy", busy, 0);
    check_output("rmo_job_ready", job_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    check_output("rmo_no_resp", bad, 0);
    apply_stimulus(KEY1, NONCE1, DATA1, ok);
    check_output("rmo2_accept", ok, 1);
    wait_resp(rise);
    check_output("rmo2_rise", rise, 47);
    check_output("rmo2_tag", resp_tag, TAG);
    check_output("rmo2_err", resp_err, 0);
    release_resp();

    repeat (3) @(negedge clk);
    check_output("bus_protocol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
